// File: rtl/cache_miss_handler.sv
//------------------------------------------------------------------------------
// Module  : cache_miss_handler
// Brief   : Load-miss refill and store write-through controller between the
//           CPU port, a direct-mapped one-word-per-line cache and data memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_miss_handler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  fill_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_req_valid,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~(ADDR_WIDTH'(3));
  localparam logic [CNT_WIDTH-1:0]  c_cnt_max    = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_resp;
  logic                  r_we;
  logic                  r_store_hit;
  logic                  r_mem_req_valid;
  logic                  r_fill_en;
  logic [DATA_WIDTH-1:0] r_fill_data;
  logic [CNT_WIDTH-1:0]  r_hit_count;
  logic [CNT_WIDTH-1:0]  r_miss_count;

  logic w_idle;
  logic w_load_hit;
  logic w_go_mem;

  assign w_idle     = (r_state == S_IDLE);
  assign w_load_hit = w_idle & cpu_req & ~cpu_we & cache_hit;
  // Any store, or a load that misses, needs a memory transaction.
  assign w_go_mem   = w_idle & cpu_req & (cpu_we | ~cache_hit);

  always_comb begin
    stall     = 1'b0;
    cpu_rdata = '0;
    case (r_state)
      S_IDLE:  stall = w_go_mem;
      S_REQ:   stall = 1'b1;
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (w_load_hit) begin
      cpu_rdata = cache_rdata;
    end else if (r_state == S_FILL && !r_we) begin
      cpu_rdata = r_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_resp          <= '0;
      r_we            <= 1'b0;
      r_store_hit     <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_fill_en       <= 1'b0;
      r_fill_data     <= '0;
      r_hit_count     <= '0;
      r_miss_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load_hit && r_hit_count != c_cnt_max) begin
            r_hit_count <= r_hit_count + 1'b1;
          end
          if (w_go_mem) begin
            r_addr          <= cpu_addr & c_align_mask;
            r_we            <= cpu_we;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_REQ;
            if (cpu_we) begin
              r_wdata     <= cpu_wdata;
              r_store_hit <= cache_hit;
            end else begin
              r_store_hit <= 1'b0;
              if (r_miss_count != c_cnt_max) begin
                r_miss_count <= r_miss_count + 1'b1;
              end
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_resp      <= mem_resp_data;
            // A store miss does not allocate; its fill strobe stays low.
            r_fill_en   <= r_we ? r_store_hit : 1'b1;
            r_fill_data <= r_we ? r_wdata : mem_resp_data;
            r_state     <= S_FILL;
          end
        end
        default: begin
          r_fill_en <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign fill_en       = r_fill_en;
  assign fill_addr     = r_addr;
  assign fill_data     = r_fill_data;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
//------------------------------------------------------------------------------
// Module  : tb_cache_miss_handler
// Brief   : Directed table-driven bench for cache_miss_handler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_miss_handler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_s = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cache_hit = 1'b0;
  logic [31:0] cache_rdata = '0;
  logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  logic        stall, fill_en, mem_req_valid, mem_req_we;
  logic [31:0] cpu_rdata, fill_addr, fill_data, mem_req_addr, mem_req_wdata;
  logic [15:0] hit_count, miss_count;

  logic        s_stall, s_fill_en, s_mem_req_valid, s_mem_req_we;
  logic [31:0] s_cpu_rdata, s_fill_addr, s_fill_data, s_mem_req_addr, s_mem_req_wdata;
  logic [1:0]  s_hit_count, s_miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_miss_handler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .stall(stall), .cpu_rdata(cpu_rdata), .cache_hit(cache_hit),
    .cache_rdata(cache_rdata), .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter instance so saturation is reached in a handful of hits.
  cache_miss_handler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst_s), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .stall(s_stall), .cpu_rdata(s_cpu_rdata), .cache_hit(cache_hit),
    .cache_rdata(cache_rdata), .fill_en(s_fill_en), .fill_addr(s_fill_addr), .fill_data(s_fill_data),
    .mem_req_valid(s_mem_req_valid), .mem_req_we(s_mem_req_we), .mem_req_addr(s_mem_req_addr),
    .mem_req_wdata(s_mem_req_wdata), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic        hit;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
    logic [15:0] exp_hc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] exp_a, input logic [31:0] d,
                          input logic h, input int hold);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cache_hit = h;
    mem_req_ready = 1'b0;
    #2 check("st_stall_idle", 32'(stall), 32'd1);
    @(negedge clk);
    cache_hit = 1'b0;
    for (int k = 0; k <= hold; k++) begin
      check("st_req_valid", 32'(mem_req_valid), 32'd1);
      check("st_req_we", 32'(mem_req_we), 32'd1);
      check("st_req_addr", mem_req_addr, exp_a);
      check("st_req_wdata", mem_req_wdata, d);
      check("st_req_stall", 32'(stall), 32'd1);
      if (k == hold) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    check("st_wait_valid", 32'(mem_req_valid), 32'd0);
    check("st_wait_stall", 32'(stall), 32'd1);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF0000;
    @(negedge clk);
    check("st_fill_en", 32'(fill_en), 32'(h));
    check("st_fill_data", fill_data, d);
    check("st_fill_addr", fill_addr, exp_a);
    check("st_fill_stall", 32'(stall), 32'd0);
    check("st_fill_rdata", cpu_rdata, 32'd0);
    mem_resp_valid = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("st_idle_fill_en", 32'(fill_en), 32'd0);
    check("st_idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_hc;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 16'd1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 32'h0,        16'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h41, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 16'd2};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h80, 32'h22222222, 1'b0, 32'h0,        16'd2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h84, 32'h00000000, 1'b0, 32'h0,        16'd3};

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_fill_en", 32'(fill_en), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    check("rst_fill_addr", fill_addr, 32'd0);
    rst = 1'b0;

    // Zero-cycle hits and idle cycles
    for (int i = 0; i < 5; i++) begin
      cpu_req = vecs[i].req; cpu_we = vecs[i].we; cache_hit = vecs[i].hit;
      cpu_addr = vecs[i].addr; cache_rdata = vecs[i].rdata;
      #2;
      check("vec_stall", 32'(stall), 32'(vecs[i].exp_stall));
      check("vec_rdata", cpu_rdata, vecs[i].exp_rdata);
      @(negedge clk);
      check("vec_hit_count", 32'(hit_count), 32'(vecs[i].exp_hc));
      check("vec_miss_count", 32'(miss_count), 32'd0);
      check("vec_mem_req_valid", 32'(mem_req_valid), 32'd0);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;

    // Load miss with immediate ready and response one cycle later
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; cache_hit = 1'b0;
    #2;
    check("miss_stall_idle", 32'(stall), 32'd1);
    check("miss_rdata_idle", cpu_rdata, 32'd0);
    @(negedge clk);
    check("miss_req_valid", 32'(mem_req_valid), 32'd1);
    check("miss_req_we", 32'(mem_req_we), 32'd0);
    check("miss_req_addr", mem_req_addr, 32'h44);
    check("miss_count", 32'(miss_count), 32'd1);
    check("miss_stall_req", 32'(stall), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("miss_wait_valid", 32'(mem_req_valid), 32'd0);
    check("miss_stall_wait", 32'(stall), 32'd1);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("miss_fill_en", 32'(fill_en), 32'd1);
    check("miss_fill_addr", fill_addr, 32'h44);
    check("miss_fill_data", fill_data, 32'h12345678);
    check("miss_stall_fill", 32'(stall), 32'd0);
    check("miss_rdata_fill", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    @(negedge clk);
    check("miss_after_fill_en", 32'(fill_en), 32'd0);
    check("miss_after_stall", 32'(stall), 32'd0);
    check("miss_after_hit_count", 32'(hit_count), 32'd3);

    // Store hit with ready held low three cycles, then store miss (unaligned)
    do_store(32'h48, 32'h48, 32'hA5A5A5A5, 1'b1, 3);
    do_store(32'h4E, 32'h4C, 32'h5A5A5A5A, 1'b0, 0);
    check("st_hit_count", 32'(hit_count), 32'd3);
    check("st_miss_count", 32'(miss_count), 32'd1);

    // Reset while waiting for a response, then a stray response
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; cache_hit = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rw_stall_wait", 32'(stall), 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rw_stall", 32'(stall), 32'd0);
    check("rw_valid", 32'(mem_req_valid), 32'd0);
    check("rw_fill_en", 32'(fill_en), 32'd0);
    check("rw_hit_count", 32'(hit_count), 32'd0);
    check("rw_miss_count", 32'(miss_count), 32'd0);
    check("rw_req_addr", mem_req_addr, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h00000BAD; mem_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stray_fill_en", 32'(fill_en), 32'd0);
      check("stray_valid", 32'(mem_req_valid), 32'd0);
      check("stray_stall", 32'(stall), 32'd0);
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cache_hit = 1'b1; cache_rdata = 32'h600DF00D;
    #2;
    check("post_rst_hit_stall", 32'(stall), 32'd0);
    check("post_rst_hit_rdata", cpu_rdata, 32'h600DF00D);
    @(negedge clk);
    check("post_rst_hit_count", 32'(hit_count), 32'd1);
    cpu_req = 1'b0;
    exp_hc = 16'd1;

    // Saturation of the narrow hit counter
    @(negedge clk);
    rst_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cache_hit = 1'b1; cache_rdata = 32'(i);
      @(negedge clk);
      exp_hc = exp_hc + 16'd1;
      check("sat_hit_count", 32'(s_hit_count), (i < 3) ? 32'(i + 1) : 32'd3);
      check("sat_main_hit_count", 32'(hit_count), 32'(exp_hc));
    end
    cpu_req = 1'b0;
    check("sat_miss_count", 32'(s_miss_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
